// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter.
// State, owner encodings and the idle address marker.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE,
        OWN_I,
        OWN_D
    } arb_owner_t;

    localparam logic [31:0] INVALID_ADDR = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_rr_pick2.sv
// Two-way round-robin picker.
// Purely combinational; at most one grant is ever high.
module mem_rr_pick2
    import mem_arb_pkg::*;
(
    input  logic       eligible_i,
    input  logic       eligible_d,
    input  arb_owner_t last_grant,
    output logic       grant_i,
    output logic       grant_d
);

    assign grant_i = eligible_i &&
                     (!eligible_d || last_grant == OWN_D);
    assign grant_d = eligible_d &&
                     (!eligible_i || last_grant != OWN_D);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between icache refill and dcache MSHR.
// One transaction in flight; a watchdog aborts lost responses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT      = 64,
    parameter logic [31:0] INVALID_ADDR = mem_arb_pkg::INVALID_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    output logic        busy,
    output logic        timeout_sticky
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    arb_state_t     state;
    arb_owner_t     owner;
    arb_owner_t     last_grant;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic           we_q;
    logic [WDW-1:0] wdog;

    logic           grant_i;
    logic           grant_d;
    logic           done;
    logic           fin_err;
    logic [31:0]    fin_data;

    // A requester is masked during its own response pulse
    mem_rr_pick2 u_pick (
        .eligible_i (i_req && !i_valid),
        .eligible_d (d_req && !d_valid),
        .last_grant (last_grant),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    always_comb begin
        done     = 1'b0;
        fin_err  = 1'b0;
        fin_data = mem_rdata;
        if (state == WAIT) begin
            done     = mem_valid || (wdog == WD_LAST);
            fin_err  = !mem_valid;
            fin_data = mem_valid ? mem_rdata : INVALID_ADDR;
        end
    end

    assign mem_req   = (state == REQ);
    assign mem_we    = we_q;
    assign mem_addr  = (owner == NONE) ? INVALID_ADDR : addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            owner          <= NONE;
            last_grant     <= OWN_I;
            addr_q         <= '0;
            wdata_q        <= '0;
            we_q           <= 1'b0;
            wdog           <= '0;
            i_valid        <= 1'b0;
            i_err          <= 1'b0;
            i_rdata        <= '0;
            d_valid        <= 1'b0;
            d_err          <= 1'b0;
            d_rdata        <= '0;
            timeout_sticky <= 1'b0;
        end else begin
            i_valid <= 1'b0;
            i_err   <= 1'b0;
            d_valid <= 1'b0;
            d_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_i || grant_d) begin
                        owner      <= grant_i ? OWN_I : OWN_D;
                        last_grant <= grant_i ? OWN_I : OWN_D;
                        addr_q     <= grant_i ? i_addr : d_addr;
                        wdata_q    <= grant_i ? '0 : d_wdata;
                        we_q       <= grant_d && d_we;
                        wdog       <= '0;
                        state      <= REQ;
                    end
                end
                REQ: state <= WAIT;
                WAIT: begin
                    if (done) begin
                        if (owner == OWN_I) begin
                            i_valid <= 1'b1;
                            i_err   <= fin_err;
                            i_rdata <= fin_data;
                        end
                        if (owner == OWN_D) begin
                            d_valid <= 1'b1;
                            d_err   <= fin_err;
                            d_rdata <= fin_data;
                        end
                        if (fin_err)
                            timeout_sticky <= 1'b1;
                        we_q  <= 1'b0;
                        owner <= NONE;
                        state <= IDLE;
                    end else if (wdog != '1) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT = 8.
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_mem_port_arbiter;

    localparam int T = 8;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_valid;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        busy;
    logic        timeout_sticky;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.TIMEOUT(T)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_valid        (i_valid),
        .i_rdata        (i_rdata),
        .i_err          (i_err),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_valid        (d_valid),
        .d_rdata        (d_rdata),
        .d_err          (d_err),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_valid      (mem_valid),
        .busy           (busy),
        .timeout_sticky (timeout_sticky)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL tb_time_limit: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_valid = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, BAD);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_i_valid", i_valid, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_sticky", timeout_sticky, 0);
        step();
        rst_n = 1'b1;

        // single icache read
        i_req  = 1'b1;
        i_addr = 32'h100;
        step();
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_busy", busy, 1);
        step();
        chk("t1_req_once", mem_req, 0);
        step();
        step();
        mem_valid = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();
        mem_valid = 1'b0;
        chk("t1_i_valid", i_valid, 1);
        chk("t1_i_rdata", i_rdata, 32'h1234_5678);
        chk("t1_i_err", i_err, 0);
        chk("t1_d_valid", d_valid, 0);
        chk("t1_idle_addr", mem_addr, BAD);
        step();
        chk("t1_no_regrant", mem_req, 0);
        chk("t1_busy_after", busy, 0);
        chk("t1_pulse_end", i_valid, 0);
        i_req = 1'b0;

        // simultaneous requests from reset
        do_reset();
        i_req   = 1'b1;
        i_addr  = 32'h200;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h300;
        d_wdata = 32'hCAFE_F00D;
        step();
        chk("t2_g1_req", mem_req, 1);
        chk("t2_g1_we", mem_we, 1);
        chk("t2_g1_addr", mem_addr, 32'h300);
        chk("t2_g1_wdata", mem_wdata, 32'hCAFE_F00D);
        step();
        step();
        mem_valid = 1'b1;
        mem_rdata = 32'hAAAA_0001;
        step();
        mem_valid = 1'b0;
        chk("t2_d_valid1", d_valid, 1);
        chk("t2_d_rdata1", d_rdata, 32'hAAAA_0001);
        chk("t2_i_quiet1", i_valid, 0);
        step();
        chk("t2_g2_req", mem_req, 1);
        chk("t2_g2_addr", mem_addr, 32'h200);
        chk("t2_g2_we", mem_we, 0);
        step();
        mem_valid = 1'b1;
        mem_rdata = 32'hBBBB_0002;
        step();
        mem_valid = 1'b0;
        chk("t2_i_valid2", i_valid, 1);
        chk("t2_i_rdata2", i_rdata, 32'hBBBB_0002);
        step();
        chk("t2_g3_req", mem_req, 1);
        chk("t2_g3_addr", mem_addr, 32'h300);
        chk("t2_g3_we", mem_we, 1);
        step();
        mem_valid = 1'b1;
        mem_rdata = 32'hCCCC_0003;
        step();
        mem_valid = 1'b0;
        chk("t2_d_valid3", d_valid, 1);
        chk("t2_d_rdata3", d_rdata, 32'hCCCC_0003);
        step();
        chk("t2_g4_req", mem_req, 1);
        chk("t2_g4_addr", mem_addr, 32'h200);
        d_req = 1'b0;
        step();
        mem_valid = 1'b1;
        mem_rdata = 32'hDDDD_0004;
        step();
        mem_valid = 1'b0;
        chk("t2_i_valid4", i_valid, 1);
        chk("t2_i_rdata4", i_rdata, 32'hDDDD_0004);
        i_req = 1'b0;
        step();
        chk("t2_quiet", mem_req, 0);

        // dcache read timeout with icache pending
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h400;
        step();
        chk("t3_req", mem_req, 1);
        chk("t3_addr", mem_addr, 32'h400);
        chk("t3_we", mem_we, 0);
        step();
        i_req  = 1'b1;
        i_addr = 32'h500;
        repeat (7) step();
        chk("t3_pre_valid", d_valid, 0);
        chk("t3_pre_busy", busy, 1);
        chk("t3_pre_sticky", timeout_sticky, 0);
        step();
        chk("t3_d_valid", d_valid, 1);
        chk("t3_d_err", d_err, 1);
        chk("t3_d_rdata", d_rdata, BAD);
        chk("t3_sticky", timeout_sticky, 1);
        d_req = 1'b0;
        step();
        chk("t3_i_grant", mem_req, 1);
        chk("t3_i_addr", mem_addr, 32'h500);
        step();
        mem_valid = 1'b1;
        mem_rdata = 32'h0000_5555;
        step();
        mem_valid = 1'b0;
        chk("t3_i_valid", i_valid, 1);
        chk("t3_i_err", i_err, 0);
        chk("t3_i_rdata", i_rdata, 32'h0000_5555);
        chk("t3_sticky_hold", timeout_sticky, 1);
        i_req = 1'b0;
        step();

        // reset in the middle of WAIT
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h600;
        d_wdata = 32'h0000_0012;
        step();
        chk("t4_req", mem_req, 1);
        step();
        chk("t4_busy", busy, 1);
        step();
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_req", mem_req, 0);
        chk("t4_rst_addr", mem_addr, BAD);
        chk("t4_rst_we", mem_we, 0);
        chk("t4_rst_sticky", timeout_sticky, 0);
        d_req = 1'b0;
        step();
        rst_n     = 1'b1;
        mem_valid = 1'b1;
        mem_rdata = 32'h0000_0099;
        step();
        mem_valid = 1'b0;
        chk("t4_late_i", i_valid, 0);
        chk("t4_late_d", d_valid, 0);
        chk("t4_late_busy", busy, 0);
        step();
        chk("t4_after_d", d_valid, 0);
        chk("t4_after_req", mem_req, 0);

        // response lands on the last watchdog cycle
        i_req  = 1'b1;
        i_addr = 32'h700;
        step();
        chk("t5_req", mem_req, 1);
        step();
        repeat (7) step();
        chk("t5_pre_valid", i_valid, 0);
        chk("t5_pre_busy", busy, 1);
        mem_valid = 1'b1;
        mem_rdata = 32'h0000_7777;
        step();
        mem_valid = 1'b0;
        chk("t5_i_valid", i_valid, 1);
        chk("t5_i_err", i_err, 0);
        chk("t5_i_rdata", i_rdata, 32'h0000_7777);
        chk("t5_sticky", timeout_sticky, 0);
        i_req = 1'b0;
        step();
        chk("t5_pulse_end", i_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
